// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI transfer register bank: CPU command
// encodings, the command field width and the transfer FSM state type.
// -----------------------------------------------------------------------------
package spi_pkg;

    localparam int W_SPI_CTRL = 2;

    localparam logic [W_SPI_CTRL-1:0] CMD_IDLE  = 2'd0;
    localparam logic [W_SPI_CTRL-1:0] CMD_WRITE = 2'd1;
    localparam logic [W_SPI_CTRL-1:0] CMD_XFER  = 2'd2;
    localparam logic [W_SPI_CTRL-1:0] CMD_RSVD  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/spi_clk_gen.sv
// -----------------------------------------------------------------------------
// spi_clk_gen
// Divides clk down to the SPI serial clock while enabled.  Each sclk half
// period lasts CLK_DIV clk cycles.  The strobes are asserted during the clk
// cycle whose closing edge moves sclk, so the caller can act on the very same
// edge that sclk changes.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   en_i         run the divider; when low the counter sits at 0, sclk at CPOL
//   sclk_o       SPI serial clock
//   lead_stb_o   one-clk strobe: the next edge moves sclk away from CPOL
//   trail_stb_o  one-clk strobe: the next edge returns sclk to CPOL
// -----------------------------------------------------------------------------
module spi_clk_gen #(
    parameter int   CLK_DIV = 4,
    parameter logic CPOL    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic sclk_o,
    output logic lead_stb_o,
    output logic trail_stb_o
);

    // A divide-by-one still needs a one-bit counter to keep widths legal.
    localparam int                W_DIV    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [W_DIV-1:0]  DIV_LAST = W_DIV'(CLK_DIV - 1);

    logic [W_DIV-1:0] div_cnt_q, div_cnt_d;
    logic             sclk_q, sclk_d;
    logic             toggle;

    always_comb begin
        div_cnt_d = '0;
        sclk_d    = CPOL;
        toggle    = 1'b0;
        if (en_i) begin
            toggle    = (div_cnt_q == DIV_LAST);
            div_cnt_d = toggle ? '0 : div_cnt_q + W_DIV'(1);
            sclk_d    = toggle ? ~sclk_q : sclk_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
            sclk_q    <= CPOL;
        end else begin
            div_cnt_q <= div_cnt_d;
            sclk_q    <= sclk_d;
        end
    end

    assign sclk_o      = sclk_q;
    assign lead_stb_o  = toggle && (sclk_q == CPOL);
    assign trail_stb_o = toggle && (sclk_q != CPOL);

endmodule

// File: rtl/spi_xfer_regbank.sv
// -----------------------------------------------------------------------------
// spi_xfer_regbank
// CPU-side register file of DEPTH words with a built-in full-duplex SPI
// master (CPHA = 0, CPOL selectable).  A transfer command shifts the
// addressed word out MSB first on mosi and writes the word received on miso
// back into the same entry, flagging completion with a one-cycle dv_spi_o.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset (aborts a running transfer)
//   cmd_i      0 idle, 1 write, 2 transfer, 3 reserved (idle)
//   addr_i     register index for cmd_i and rdata_o
//   wd_i       write data for a write command
//   rdata_o    combinational read of the addressed entry
//   busy_o     transfer in progress
//   dv_spi_o   one-cycle pulse when spi_out_o holds a freshly received word
//   spi_out_o  last received word
//   sclk_o     SPI clock
//   cs_n_o     chip select, active low
//   mosi_o     serial data out, MSB first
//   miso_i     serial data in, MSB first
// -----------------------------------------------------------------------------
module spi_xfer_regbank
    import spi_pkg::*;
#(
    parameter int   W_DATA  = 32,
    parameter int   DEPTH   = 32,
    parameter int   W_ADDR  = $clog2(DEPTH),
    parameter int   CLK_DIV = 4,
    parameter logic CPOL    = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [W_SPI_CTRL-1:0] cmd_i,
    input  logic [W_ADDR-1:0]     addr_i,
    input  logic [W_DATA-1:0]     wd_i,
    output logic [W_DATA-1:0]     rdata_o,
    output logic                  busy_o,
    output logic                  dv_spi_o,
    output logic [W_DATA-1:0]     spi_out_o,
    output logic                  sclk_o,
    output logic                  cs_n_o,
    output logic                  mosi_o,
    input  logic                  miso_i
);

    localparam int               W_BIT    = $clog2(W_DATA);
    localparam logic [W_BIT-1:0] BIT_LAST = W_BIT'(W_DATA - 1);

    logic [W_DATA-1:0] rf_q [DEPTH];

    state_t            state_q, state_d;
    logic [W_ADDR-1:0] addr_q, addr_d;
    logic [W_DATA-1:0] shreg_q, shreg_d;
    logic [W_BIT-1:0]  bit_cnt_q, bit_cnt_d;
    logic              mosi_q, mosi_d;
    logic              cs_n_q, cs_n_d;
    logic              busy_q, busy_d;
    logic              dv_spi_q, dv_spi_d;
    logic [W_DATA-1:0] spi_out_q, spi_out_d;

    logic              lead_stb, trail_stb;
    logic              wr_en, done_wr;

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV),
        .CPOL    (CPOL)
    ) u_clk_gen (
        .clk         (clk),
        .rst         (rst),
        .en_i        (state_q == SHIFT),
        .sclk_o      (sclk_o),
        .lead_stb_o  (lead_stb),
        .trail_stb_o (trail_stb)
    );

    // The entry being transferred belongs to the shifter until DONE, so a CPU
    // write aimed at it is dropped and the received word wins.
    assign wr_en = (cmd_i == CMD_WRITE) && !(busy_q && (addr_i == addr_q));

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        mosi_d    = mosi_q;
        cs_n_d    = cs_n_q;
        busy_d    = busy_q;
        dv_spi_d  = 1'b0;
        spi_out_d = spi_out_q;
        done_wr   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cmd_i == CMD_XFER) begin
                    addr_d    = addr_i;
                    shreg_d   = rf_q[addr_i];
                    mosi_d    = rf_q[addr_i][W_DATA-1];
                    cs_n_d    = 1'b0;
                    busy_d    = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end

            SHIFT: begin
                if (lead_stb) begin
                    shreg_d = {shreg_q[W_DATA-2:0], miso_i};
                end
                // The leading edge already shifted, so the MSB now holds the
                // next bit to present on mosi.
                if (trail_stb) begin
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + W_BIT'(1);
                        mosi_d    = shreg_q[W_DATA-1];
                    end
                end
            end

            DONE: begin
                done_wr   = 1'b1;
                spi_out_d = shreg_q;
                dv_spi_d  = 1'b1;
                cs_n_d    = 1'b1;
                mosi_d    = 1'b0;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            dv_spi_q  <= 1'b0;
            spi_out_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
            busy_q    <= busy_d;
            dv_spi_q  <= dv_spi_d;
            spi_out_q <= spi_out_d;
        end
    end

    // A CPU write and the write-back can share an edge only when their
    // addresses differ (wr_en excludes addr_q while busy), so they never clash.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                rf_q[addr_i] <= wd_i;
            end
            if (done_wr) begin
                rf_q[addr_q] <= shreg_q;
            end
        end
    end

    assign rdata_o   = rf_q[addr_i];
    assign busy_o    = busy_q;
    assign dv_spi_o  = dv_spi_q;
    assign spi_out_o = spi_out_q;
    assign cs_n_o    = cs_n_q;
    assign mosi_o    = mosi_q;

endmodule
